spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
SPI master controller that sequences the TX and RX spi_fifo instances. It pops words from the TX FIFO and shifts each one out as a mode-0 SPI frame (CPOL=0, CPHA=0, MSB first). It captures MISO in parallel and pushes each received word into the RX FIFO. It sits between the two FIFOs and the SPI pads, and is the only agent driving TX rd_en and RX wr_en.

Parameters:
DATA_WIDTH, `SPI_DATA_WIDTH (8), frame/word width in bits; must match the FIFOs.
CLK_DIV, 2, clk cycles per SCLK half-period; minimum 1.
GAP_CYCLES, 2, cs_n high cycles enforced between consecutive frames; minimum 1.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = start frames while TX FIFO is non-empty
tx_dout  in  DATA_WIDTH  TX FIFO show-ahead head word
tx_empty  in  1  TX FIFO empty flag
tx_rd_en  out  1  TX FIFO pop strobe
rx_din  out  DATA_WIDTH  word written to RX FIFO
rx_full  in  1  RX FIFO full flag
rx_wr_en  out  1  RX FIFO push strobe
sclk  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in
cs_n  out  1  SPI chip select, active low
busy  out  1  1 in any state other than IDLE
rx_stall  out  1  1 while a received word waits for RX FIFO space

Behaviour:
- Reset is asynchronous. While rst_n=0 or after reset: state=IDLE, sclk=0, mosi=0, cs_n=1, tx_rd_en=0, rx_wr_en=0, rx_din=0, busy=0, rx_stall=0, and all counters and shift registers are 0. Asserting reset mid-frame aborts the frame; no FIFO strobe is issued.
- The tx_rd_en and rx_wr_en strobes are asserted for exactly one cycle each. All other outputs are registered.
- IDLE: when enable=1 and tx_empty=0, drive tx_rd_en=1 combinationally for that cycle. On that edge: capture tx_dout into the TX shift register, set cs_n<=0, set mosi<=tx_dout[DATA_WIDTH-1], go to SETUP. Otherwise stay in IDLE.
- SETUP: hold for CLK_DIV cycles with sclk=0, then go to SHIFT.
- SHIFT: the divider counts 0..CLK_DIV-1. On wrap, sclk toggles.
  - Rising SCLK edge: shift miso into the RX shift register (LSB in) and increment the bit counter.
  - Falling SCLK edge after bit k (k less than DATA_WIDTH): drive the next bit on mosi.
  - After the falling edge that follows the DATA_WIDTH-th rising edge, go to PUSH with sclk=0 and cs_n<=1.
  - cs_n is low for exactly (2*DATA_WIDTH+1)*CLK_DIV cycles: 34 cycles at the defaults.
- PUSH: rx_din holds the received word. If rx_full=0, assert rx_wr_en for one cycle and go to GAP. If rx_full=1, stay in PUSH with rx_stall=1 and no data loss; push on the first cycle rx_full=0.
- GAP: cs_n=1 for GAP_CYCLES cycles, then go to IDLE. Back-to-back frames are therefore separated by at least GAP_CYCLES+1 cs_n-high cycles, counting the IDLE pop cycle.
- enable is sampled only in IDLE. Deasserting it mid-frame lets the current frame finish, including PUSH and GAP.
- tx_rd_en is never asserted when tx_empty=1. rx_wr_en is never asserted when rx_full=1.
- mosi holds its last bit after a frame ends; it is don't-care while cs_n=1.

Test Plan:
- Loopback (miso=mosi), CLK_DIV=2, push 0xA5 into TX FIFO, enable=1 -> exactly 8 sclk pulses; cs_n low for 34 cycles; RX FIFO receives 0xA5; one tx_rd_en pulse and one rx_wr_en pulse.
- Back-to-back: push 0x01, 0x80, 0xFF in loopback -> three frames, each separated by at least 3 cs_n-high cycles; RX FIFO order is 0x01, 0x80, 0xFF; TX FIFO ends empty and busy=0.
- miso tied to 1 while sending 0x00 -> rx_din=0xFF; mosi stays 0 for the whole frame.
- RX FIFO pre-filled to full, send one word -> after the frame, rx_stall=1 and rx_wr_en=0 until one RX word is popped; then the word is pushed on the next cycle and rx_stall=0.
- enable=0 with TX non-empty -> no tx_rd_en, cs_n=1, sclk=0 indefinitely. Drop enable at bit 3 of a frame -> that frame completes and no next frame starts.
- Assert rst_n=0 at bit 5 of a frame -> cs_n=1, sclk=0, busy=0 immediately; no rx_wr_en is issued; after release the controller restarts from IDLE.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: pops words from a show-ahead TX FIFO, shifts them out MSB first,
// and pushes the word captured on MISO into the RX FIFO, stalling while the RX FIFO is full.
`ifndef SPI_DATA_WIDTH
`define SPI_DATA_WIDTH 8
`endif

module spi_master_ctrl #(
  parameter int DATA_WIDTH = `SPI_DATA_WIDTH,
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] tx_dout,
  input  logic                  tx_empty,
  output logic                  tx_rd_en,
  output logic [DATA_WIDTH-1:0] rx_din,
  input  logic                  rx_full,
  output logic                  rx_wr_en,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  rx_stall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, PUSH, GAP} state_t;

  state_t                state, state_next;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  start;
  logic                  div_wrap;
  logic                  last_fall;
  logic                  gap_done;

  assign start     = enable && !tx_empty;
  assign div_wrap  = (div_cnt == DIV_W'(CLK_DIV - 1));
  // The falling SCLK edge after the final rising edge closes the frame.
  assign last_fall = div_wrap && sclk && (bit_cnt == BIT_W'(DATA_WIDTH));
  assign gap_done  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = SETUP;
      SETUP:   if (div_wrap)  state_next = SHIFT;
      SHIFT:   if (last_fall) state_next = PUSH;
      PUSH:    if (!rx_full)  state_next = GAP;
      GAP:     if (gap_done)  state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // FIFO strobes are combinational so they can never fire against empty/full.
  always_comb begin
    tx_rd_en = (state == IDLE) && start;
    rx_wr_en = (state == PUSH) && !rx_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      rx_stall <= 1'b0;
      rx_din   <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      busy     <= (state_next != IDLE);
      rx_stall <= (state == PUSH) && rx_full;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sr   <= tx_dout;
            mosi    <= tx_dout[DATA_WIDTH-1];
            cs_n    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            rx_sr   <= '0;
          end
        end
        SETUP: begin
          div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
        end
        SHIFT: begin
          div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
          if (div_wrap) begin
            if (!sclk) begin
              sclk    <= 1'b1;
              rx_sr   <= {rx_sr[DATA_WIDTH-2:0], miso};
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_cnt < BIT_W'(DATA_WIDTH)) begin
                tx_sr <= tx_sr << 1;
                mosi  <= tx_sr[DATA_WIDTH-2];
              end else begin
                cs_n   <= 1'b1;
                rx_din <= rx_sr;
              end
            end
          end
        end
        PUSH: begin
          gap_cnt <= '0;
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          cs_n <= 1'b1;
          sclk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: bench-side TX FIFO model, expected-word
// scoreboard popped by a negedge monitor, plus frame timing counters.
module tb_spi_master_ctrl;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] tx_dout;
  logic          tx_empty;
  logic          tx_rd_en;
  logic [DW-1:0] rx_din;
  logic          rx_full = 1'b0;
  logic          rx_wr_en;
  logic          sclk;
  logic          mosi;
  logic          miso;
  logic          cs_n;
  logic          busy;
  logic          rx_stall;
  logic          loopback = 1'b1;
  logic          miso_force = 1'b0;

  spi_master_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(2), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .tx_dout(tx_dout), .tx_empty(tx_empty), .tx_rd_en(tx_rd_en),
    .rx_din(rx_din), .rx_full(rx_full), .rx_wr_en(rx_wr_en),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n),
    .busy(busy), .rx_stall(rx_stall)
  );

  always #5 clk = ~clk;

  // TX FIFO model: stimulus owns the write pointer, the pop process owns the read pointer.
  logic [DW-1:0] tx_mem [0:63];
  int            tx_wp = 0;
  int            tx_rp = 0;
  assign tx_dout  = tx_mem[tx_rp[5:0]];
  assign tx_empty = (tx_rp == tx_wp);
  assign miso     = loopback ? mosi : miso_force;

  always @(posedge clk) if (tx_rd_en) tx_rp <= tx_rp + 1;

  logic [DW-1:0] exp_q [$];
  int n_chk = 0, n_pass = 0;
  int sclk_rises, cs_low_cyc, rd_pulses, wr_pulses, mosi_ones, min_gap, high_run;
  logic sclk_prev, frame_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_rd_en) begin
        rd_pulses++;
        check("rd_en_while_empty", 32'(tx_empty), 32'd0);
      end
      if (rx_wr_en) begin
        wr_pulses++;
        check("wr_en_while_full", 32'(rx_full), 32'd0);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_push: got 0x%0h, expected no push", rx_din);
        end else begin
          check("rx_word", 32'(rx_din), 32'(exp_q.pop_front()));
        end
      end
      if (!sclk_prev && sclk) sclk_rises++;
      sclk_prev = sclk;
      if (!cs_n) begin
        cs_low_cyc++;
        if (mosi) mosi_ones++;
        if (frame_seen && high_run > 0 && high_run < min_gap) min_gap = high_run;
        high_run   = 0;
        frame_seen = 1'b1;
      end else if (frame_seen) begin
        high_run++;
      end
    end
  end

  task automatic clear_stats();
    sclk_rises = 0; cs_low_cyc = 0; rd_pulses = 0; wr_pulses = 0; mosi_ones = 0;
    min_gap = 1000; high_run = 0; frame_seen = 1'b0; sclk_prev = sclk;
  endtask

  task automatic tx_push(input logic [DW-1:0] w);
    tx_mem[tx_wp[5:0]] = w;
    tx_wp++;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    logic done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy && cs_n && tx_empty && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check({name, "_done"}, 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rises(input int k);
    logic hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sclk_rises >= k) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_bit", 32'(hit), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_stats();
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_stall", 32'(rx_stall), 32'd0);
    check("rst_rx_din", 32'(rx_din), 32'd0);
    check("rst_strobes", 32'({tx_rd_en, rx_wr_en}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single loopback frame
    clear_stats();
    enable = 1'b1;
    exp_q.push_back(8'hA5);
    tx_push(8'hA5);
    wait_done("t1");
    check("t1_sclk_pulses", 32'(sclk_rises), 32'd8);
    check("t1_cs_low", 32'(cs_low_cyc), 32'd34);
    check("t1_rd_pulses", 32'(rd_pulses), 32'd1);
    check("t1_wr_pulses", 32'(wr_pulses), 32'd1);

    // Back-to-back frames
    clear_stats();
    exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'hFF);
    tx_push(8'h01); tx_push(8'h80); tx_push(8'hFF);
    wait_done("t2");
    check("t2_sclk_pulses", 32'(sclk_rises), 32'd24);
    check("t2_cs_low", 32'(cs_low_cyc), 32'd102);
    check("t2_rd_pulses", 32'(rd_pulses), 32'd3);
    check("t2_wr_pulses", 32'(wr_pulses), 32'd3);
    check("t2_min_gap_ge3", 32'(min_gap >= 3), 32'd1);
    check("t2_tx_empty", 32'(tx_empty), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);

    // MISO tied high while sending zero
    loopback = 1'b0; miso_force = 1'b1;
    clear_stats();
    exp_q.push_back(8'hFF);
    tx_push(8'h00);
    wait_done("t3");
    check("t3_mosi_high_cycles", 32'(mosi_ones), 32'd0);
    check("t3_sclk_pulses", 32'(sclk_rises), 32'd8);
    loopback = 1'b1;

    // RX FIFO full: stall until space appears
    rx_full = 1'b1;
    clear_stats();
    exp_q.push_back(8'h3C);
    tx_push(8'h3C);
    wait_cycles(45);
    @(negedge clk);
    check("t4_stall", 32'(rx_stall), 32'd1);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_no_push", 32'(wr_pulses), 32'd0);
    @(posedge clk); #1 rx_full = 1'b0;
    @(negedge clk);
    check("t4_push_strobe", 32'(rx_wr_en), 32'd1);
    @(negedge clk);
    check("t4_stall_clear", 32'(rx_stall), 32'd0);
    wait_done("t4");
    check("t4_wr_pulses", 32'(wr_pulses), 32'd1);

    // Enable low holds off; dropping it mid-frame finishes only that frame
    enable = 1'b0;
    clear_stats();
    tx_push(8'h55); tx_push(8'h66);
    wait_cycles(40);
    check("t5_idle_rd", 32'(rd_pulses), 32'd0);
    check("t5_idle_cs_low", 32'(cs_low_cyc), 32'd0);
    check("t5_idle_sclk", 32'(sclk_rises), 32'd0);
    exp_q.push_back(8'h55);
    enable = 1'b1;
    wait_rises(3);
    enable = 1'b0;
    wait_cycles(80);
    check("t5_rd_pulses", 32'(rd_pulses), 32'd1);
    check("t5_wr_pulses", 32'(wr_pulses), 32'd1);
    check("t5_tx_left", 32'(tx_empty), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cs_n", 32'(cs_n), 32'd1);
    exp_q.push_back(8'h66);
    enable = 1'b1;
    wait_done("t5b");

    // Reset mid-frame aborts with no push
    clear_stats();
    tx_push(8'h99);
    wait_rises(5);
    rst_n = 1'b0;
    #1;
    check("t6_cs_n", 32'(cs_n), 32'd1);
    check("t6_sclk", 32'(sclk), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("t6_no_wr_in_reset", 32'(rx_wr_en), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_cycles(5);
    check("t6_no_push_after", 32'(wr_pulses), 32'd0);
    check("t6_idle_after", 32'(busy), 32'd0);
    clear_stats();
    exp_q.push_back(8'h42);
    tx_push(8'h42);
    wait_done("t6b");
    check("t6b_wr_pulses", 32'(wr_pulses), 32'd1);
    check("t6b_cs_low", 32'(cs_low_cyc), 32'd34);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
